// File: rtl/banco_reg_multi.sv
// DEPTH x DATA_W register bank: two async read ports, two prioritised write ports, self-clearing
// after reset or ClearReq. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module banco_reg_multi #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ClearReq,
   input  logic              RegEn1,
   input  logic [ADDR_W-1:0] WriteReg1,
   input  logic [DATA_W-1:0] WriteData1,
   input  logic              RegEn2,
   input  logic [ADDR_W-1:0] WriteReg2,
   input  logic [DATA_W-1:0] WriteData2,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              Ready
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [ADDR_W:0]   clrCnt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              wrOk1, wrOk2;

   assign wrOk1 = RegEn1 && !(ZERO_REG != 0 && WriteReg1 == '0);
   assign wrOk2 = RegEn2 && !(ZERO_REG != 0 && WriteReg2 == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CLEAR;
         clrCnt <= '0;
         Ready  <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clrCnt <= clrCnt + 1'b1;
               if (clrCnt == (ADDR_W+1)'(DEPTH - 1)) begin
                  state <= RUN;
                  Ready <= 1'b1;
               end
            end
            RUN: begin
               if (ClearReq) begin
                  state  <= CLEAR;
                  clrCnt <= '0;
                  Ready  <= 1'b0;
               end
            end
            default: begin
               state  <= CLEAR;
               clrCnt <= '0;
               Ready  <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; the clear sequencer zeroes one entry per edge instead.
   // Port 2 is written last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         regs[clrCnt[ADDR_W-1:0]] <= '0;
      end else begin
         if (wrOk1) regs[WriteReg1] <= WriteData1;
         if (wrOk2) regs[WriteReg2] <= WriteData2;
      end
   end

   logic [ADDR_W-1:0] rdAddr [2];
   logic [DATA_W-1:0] rdData [2];

   assign rdAddr[0] = ReadReg1;
   assign rdAddr[1] = ReadReg2;

   for (genvar p = 0; p < 2; p++) begin : gRead
      logic [DATA_W-1:0] d;
      always_comb begin
         d = regs[rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
         if (RegEn1 && WriteReg1 == rdAddr[p]) d = WriteData1;
         if (RegEn2 && WriteReg2 == rdAddr[p]) d = WriteData2;
`endif
         // Zero-register masking and clear-in-progress override any forwarded value.
         if (state == CLEAR || (ZERO_REG != 0 && rdAddr[p] == '0)) d = '0;
      end
      assign rdData[p] = d;
   end

   assign ReadData1 = rdData[0];
   assign ReadData2 = rdData[1];

endmodule

// File: tb/tb_banco_reg_multi.sv
// Scoreboard bench for banco_reg_multi: directed test-plan sequences then random traffic,
// checked against an abstract array model (clear modelled as instant wipe + busy countdown).
module tb_banco_reg_multi;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ClearReq;
   logic          RegEn1, RegEn2;
   logic [AW-1:0] WriteReg1, WriteReg2, ReadReg1, ReadReg2;
   logic [DW-1:0] WriteData1, WriteData2, ReadData1, ReadData2;
   logic          Ready;

   always #5 clk = ~clk;

   banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .ClearReq(ClearReq),
      .RegEn1(RegEn1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
      .RegEn2(RegEn2), .WriteReg2(WriteReg2), .WriteData2(WriteData2),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .Ready(Ready)
   );

   typedef struct packed {
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic          rdy;
   } exp_t;

   exp_t          expQ[$];
   logic [DW-1:0] mem [DEPTH];
   int            clearLeft;
   bit            rstHold;
   int            nVec = 0;
   int            nErr = 0;

   function automatic logic [DW-1:0] expRead(input int a);
      if (clearLeft > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (RegEn2 && int'(WriteReg2) == a) return WriteData2;
      if (RegEn1 && int'(WriteReg1) == a) return WriteData1;
`endif
      return mem[a];
   endfunction

   task automatic startClear();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      clearLeft = DEPTH;
   endtask

   task automatic modelEdge();
      if (clearLeft > 0) clearLeft--;
      else begin
         if (RegEn1 && WriteReg1 != 0) mem[WriteReg1] = WriteData1;
         if (RegEn2 && WriteReg2 != 0) mem[WriteReg2] = WriteData2;
         if (ClearReq) startClear();
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      startClear();
      rstHold = 1'b1;
   endtask

   // One cycle: drive inputs, queue expected outputs, advance past the edge, update model.
   task automatic step(input logic e1, input int a1, input logic [DW-1:0] d1,
                       input logic e2, input int a2, input logic [DW-1:0] d2,
                       input int r1, input int r2, input logic clr);
      exp_t e;
      RegEn1 = e1; WriteReg1 = a1[AW-1:0]; WriteData1 = d1;
      RegEn2 = e2; WriteReg2 = a2[AW-1:0]; WriteData2 = d2;
      ReadReg1 = r1[AW-1:0]; ReadReg2 = r2[AW-1:0]; ClearReq = clr;
      e.rd1 = expRead(r1);
      e.rd2 = expRead(r2);
      e.rdy = (clearLeft == 0);
      expQ.push_back(e);
      @(posedge clk); #1;
      if (rstHold) begin
         rstHold = 1'b0;
         rst_n   = 1'b1;
      end else modelEdge();
   endtask

   task automatic idle(input int r1, input int r2);
      step(1'b0, 0, '0, 1'b0, 0, '0, r1, r2, 1'b0);
   endtask

   task automatic randStep(input logic clr);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 7), $urandom_range(0, DEPTH-1), clr);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            nVec++;
            if (ReadData1 !== e.rd1) begin
               nErr++;
               $display("FAIL ReadData1 got %h want %h addr %0d t=%0t", ReadData1, e.rd1, ReadReg1, $time);
            end
            if (ReadData2 !== e.rd2) begin
               nErr++;
               $display("FAIL ReadData2 got %h want %h addr %0d t=%0t", ReadData2, e.rd2, ReadReg2, $time);
            end
            if (Ready !== e.rdy) begin
               nErr++;
               $display("FAIL Ready got %b want %b t=%0t", Ready, e.rdy, $time);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; ClearReq = 1'b0;
      RegEn1 = 1'b0; WriteReg1 = '0; WriteData1 = '0;
      RegEn2 = 1'b0; WriteReg2 = '0; WriteData2 = '0;
      ReadReg1 = '0; ReadReg2 = '0;
      startClear();
      @(posedge clk); #1;

      // Reset release and full clear; writes during clear must be ignored.
      doReset();
      idle(1, 2);
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 4, 32'hA5A5_0000 + DW'(i), 1'b1, 6, 32'h5A5A_0000, 4, 6, 1'b0);
      for (int i = 0; i < DEPTH/2; i++) idle(2*i, 2*i+1);

      // Basic write / read.
      step(1'b1, 2, 32'hDEAD_BEEF, 1'b0, 0, '0, 2, 3, 1'b0);
      idle(2, 3);

      // Collision, port 2 wins; zero register stays 0.
      step(1'b1, 3, 32'h1111_1111, 1'b1, 3, 32'hCAFE_BABE, 3, 2, 1'b0);
      idle(3, 0);
      step(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 1'b0);
      idle(0, 3);

      // Same-cycle read of an address being written.
      step(1'b1, 5, 32'h1234_5678, 1'b0, 0, '0, 5, 5, 1'b0);
      idle(5, 2);
      step(1'b1, 6, 32'h0BAD_F00D, 1'b1, 6, 32'h600D_CAFE, 7, 6, 1'b0);
      idle(6, 6);

      // ClearReq in RUN with a same-cycle write, then writes ignored for the whole clear.
      step(1'b1, 9, 32'h9999_9999, 1'b0, 0, '0, 2, 9, 1'b1);
      for (int i = 0; i < DEPTH; i++) randStep(1'b0);
      idle(2, 9);
      idle(3, 5);

      // Async reset at clear cycle 10: clear restarts from entry 0.
      step(1'b0, 0, '0, 1'b0, 0, '0, 1, 2, 1'b1);
      for (int i = 0; i < 10; i++) randStep(1'b0);
      doReset();
      for (int i = 0; i < DEPTH + 2; i++) randStep(1'b0);

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) doReset();
         randStep(1'($urandom_range(0, 63) == 0));
      end

      for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         nErr++;
         $display("FAIL drain got %0d pending want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
